// File: rtl/pipelined_csel_adder.sv
// -----------------------------------------------------------------------------
// pipelined_csel_adder
//
// Pipelined carry-select adder/subtractor. Operands are split into BLOCK-bit
// blocks. Both candidate sums (carry-in 0 and carry-in 1) of every block are
// formed when a beat is accepted. Each of the NBLK pipeline stages then picks
// one block's candidate using the carry resolved by the stage before it.
// The whole pipeline stalls when the output beat is not taken.
//
// Parameters
//   WIDTH     operand / sum width, integer multiple of BLOCK
//   BLOCK     carry-select block width; NBLK = WIDTH/BLOCK stages
//
// Ports
//   clk       system clock, all state on rising edge
//   rst       synchronous active-high reset
//   in_valid  operand beat present
//   in_ready  beat can be accepted this cycle (combinational from out_*)
//   a, b      operands (unsigned or two's complement)
//   cin       carry-in, add mode only
//   sub       0: a+b+cin, 1: a-b
//   out_valid result beat present
//   out_ready downstream accepts result
//   sum       result bits
//   cout      carry-out; in sub mode 1 means no borrow
//   ovf       signed two's-complement overflow
// -----------------------------------------------------------------------------
module pipelined_csel_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = (BLOCK < 1) ? 1 : WIDTH / BLOCK;
  localparam logic [BLOCK:0] ONE = 1;

  if (BLOCK < 1) begin : g_bad_block
    $fatal(1, "pipelined_csel_adder: BLOCK must be >= 1");
  end else if ((WIDTH % BLOCK) != 0) begin : g_bad_width
    $fatal(1, "pipelined_csel_adder: WIDTH must be a multiple of BLOCK");
  end

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] bb;
  logic             c_in0;
  logic [WIDTH-1:0] ps0;
  logic [WIDTH-1:0] ps1;
  logic [NBLK-1:0]  pc0;
  logic [NBLK-1:0]  pc1;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Subtraction is a + ~b + 1; the external carry-in only matters for add.
  assign bb    = sub ? ~b : b;
  assign c_in0 = sub | cin;

  // Per-block candidate sums and carries for both possible carry-ins.
  always_comb begin
    ps0 = '0;
    ps1 = '0;
    pc0 = '0;
    pc1 = '0;
    for (int j = 0; j < NBLK; j++) begin
      {pc0[j], ps0[j*BLOCK +: BLOCK]} = {1'b0, a[j*BLOCK +: BLOCK]}
                                      + {1'b0, bb[j*BLOCK +: BLOCK]};
      {pc1[j], ps1[j*BLOCK +: BLOCK]} = {1'b0, a[j*BLOCK +: BLOCK]}
                                      + {1'b0, bb[j*BLOCK +: BLOCK]} + ONE;
    end
  end

  // Stage k holds blocks 0..k resolved (res_q), the carry out of block k
  // (cy_q) and, while blocks remain, the candidate sums/carries of blocks
  // k+1..NBLK-1 (g_rem). Each stage is sized to exactly what it still needs.
  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    localparam int RES_W = (k + 1) * BLOCK;
    localparam int REM_W = WIDTH - RES_W;
    localparam int REM_N = NBLK - 1 - k;

    logic             en;
    logic             vld_q;
    logic             vld_d;
    logic [RES_W-1:0] res_q;
    logic [RES_W-1:0] res_d;
    logic             cy_q;
    logic             cy_d;
    logic             amsb_q;
    logic             amsb_d;
    logic             bmsb_q;
    logic             bmsb_d;

    // Stage 0 data only loads on an accepted beat; later stages shift
    // whenever the pipeline moves, carrying bubbles along like full beats.
    assign en = (k == 0) ? accept : ~stall;

    if (k == 0) begin : g_first
      always_comb begin
        vld_d  = accept;
        res_d  = c_in0 ? ps1[BLOCK-1:0] : ps0[BLOCK-1:0];
        cy_d   = c_in0 ? pc1[0] : pc0[0];
        amsb_d = a[WIDTH-1];
        bmsb_d = bb[WIDTH-1];
      end
    end else begin : g_next
      always_comb begin
        vld_d  = g_stg[k-1].vld_q;
        res_d  = {(g_stg[k-1].cy_q ? g_stg[k-1].g_rem.p1_q[BLOCK-1:0]
                                   : g_stg[k-1].g_rem.p0_q[BLOCK-1:0]),
                  g_stg[k-1].res_q};
        cy_d   = g_stg[k-1].cy_q ? g_stg[k-1].g_rem.g1_q[0]
                                 : g_stg[k-1].g_rem.g0_q[0];
        amsb_d = g_stg[k-1].amsb_q;
        bmsb_d = g_stg[k-1].bmsb_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        res_q  <= '0;
        cy_q   <= 1'b0;
        amsb_q <= 1'b0;
        bmsb_q <= 1'b0;
      end else begin
        if (!stall) begin
          vld_q <= vld_d;
        end
        if (en) begin
          res_q  <= res_d;
          cy_q   <= cy_d;
          amsb_q <= amsb_d;
          bmsb_q <= bmsb_d;
        end
      end
    end

    if (REM_W > 0) begin : g_rem
      logic [REM_W-1:0] p0_q;
      logic [REM_W-1:0] p0_d;
      logic [REM_W-1:0] p1_q;
      logic [REM_W-1:0] p1_d;
      logic [REM_N-1:0] g0_q;
      logic [REM_N-1:0] g0_d;
      logic [REM_N-1:0] g1_q;
      logic [REM_N-1:0] g1_d;

      if (k == 0) begin : g_load
        assign p0_d = ps0[WIDTH-1:BLOCK];
        assign p1_d = ps1[WIDTH-1:BLOCK];
        assign g0_d = pc0[NBLK-1:1];
        assign g1_d = pc1[NBLK-1:1];
      end else begin : g_shift
        // Drop the block the previous stage just handed over.
        assign p0_d = g_stg[k-1].g_rem.p0_q[REM_W+BLOCK-1:BLOCK];
        assign p1_d = g_stg[k-1].g_rem.p1_q[REM_W+BLOCK-1:BLOCK];
        assign g0_d = g_stg[k-1].g_rem.g0_q[REM_N:1];
        assign g1_d = g_stg[k-1].g_rem.g1_q[REM_N:1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          p0_q <= '0;
          p1_q <= '0;
          g0_q <= '0;
          g1_q <= '0;
        end else if (en) begin
          p0_q <= p0_d;
          p1_q <= p1_d;
          g0_q <= g0_d;
          g1_q <= g1_d;
        end
      end
    end
  end

  assign out_valid = g_stg[NBLK-1].vld_q;
  assign sum       = g_stg[NBLK-1].res_q;
  assign cout      = g_stg[NBLK-1].cy_q;
  // Overflow: both effective operands share a sign and the result does not.
  assign ovf       = (g_stg[NBLK-1].amsb_q == g_stg[NBLK-1].bmsb_q)
                  && (g_stg[NBLK-1].res_q[WIDTH-1] != g_stg[NBLK-1].amsb_q);

endmodule

// File: doc/pipelined_csel_adder.md
Name: pipelined_csel_adder

Overview:
Parametrised, pipelined carry-select adder/subtractor, the next generation of the team's 4-bit ripple adder. Operands split into BLOCK-bit blocks. Each block precomputes its sum for carry-in 0 and carry-in 1; one pipeline stage per block resolves the carry select. A valid/ready handshake with whole-pipeline stall lets it sit between the switch/button input logic and the display/accumulator logic on the Nexys A7 design.

Parameters:
WIDTH, 16, operand and sum width in bits; must be an integer multiple of BLOCK.
BLOCK, 4, carry-select block width in bits; NBLK = WIDTH/BLOCK pipeline stages.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat present
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A (unsigned or two's complement)
b  input  WIDTH  operand B
cin  input  1  carry-in; used in add mode only
sub  input  1  0 = a+b+cin, 1 = a-b
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result bits
cout  output  1  carry-out; in sub mode 1 = no borrow (a >= b unsigned)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Elaboration: WIDTH % BLOCK != 0 or BLOCK < 1 is a fatal elaboration error.
- Effective operation: bb = sub ? ~b : b; c0 = sub ? 1 : cin; result = a + bb + c0, computed as (WIDTH+1) bits. Unsigned wrap-around of sum is modulo 2^WIDTH.
- ovf = (a[MSB] == bb[MSB]) && (sum[MSB] != a[MSB]).
- Pipeline: NBLK stages, each with a valid bit.
  - Stage 0 captures a, bb and c0 on acceptance. It also captures both candidate sums/carries for every block.
  - Stage k (k = 0..NBLK-1) selects block k's sum/carry from the incoming carry. It forwards the resolved carry and the remaining unresolved blocks to stage k+1.
  - Resolved lower blocks are carried along unchanged.
- Latency: a beat accepted at edge N presents out_valid=1 with its result after edge N+NBLK-1, i.e. NBLK cycles. With BLOCK = WIDTH, latency is 1.
- Throughput: one beat per cycle while not stalled. Beats emerge in acceptance order.
- Handshake:
  - stall = out_valid && !out_ready.
  - in_ready = !stall, and is combinational from out_valid/out_ready.
  - Accept occurs when in_valid && in_ready.
  - When stalled, all stage registers and valids hold.
  - A transfer occurs when out_valid && out_ready.
  - a, b, cin and sub are sampled only on accept.
- Bubbles are not collapsed: an empty stage advances like a full one when not stalled.
- out_valid may deassert between beats. sum, cout and ovf are don't-care when out_valid=0 but must hold stable while out_valid && !out_ready.
- Reset:
  - rst=1 at an edge clears every stage valid, so out_valid=0 the following cycle.
  - Data registers, sum, cout and ovf are cleared to 0.
  - in_ready=1 during and after reset.
  - Any beats in flight at reset are discarded, never emitted.
  - in_valid is ignored on a reset cycle.
- Simultaneous accept and output transfer in the same cycle is legal and required for full throughput.

Test Plan:
- Reset/idle, WIDTH=16, BLOCK=4: hold rst 2 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0, in_ready=1; no beat emerges afterwards.
- Latency and add: a=16'h00FF, b=16'h0001, cin=0, sub=0, out_ready=1 -> out_valid exactly 4 cycles later, sum=16'h0100, cout=0, ovf=0. With cin=1, sum=16'h0101.
- Carry chain/overflow: a=16'hFFFF, b=16'h0001 -> sum=16'h0000, cout=1, ovf=0. a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1.
- Subtract: a=16'h0005, b=16'h0007, sub=1, cin=1 -> sum=16'hFFFE, cout=0, ovf=0. a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
- Back-to-back and backpressure: drive 8 consecutive beats. Drop out_ready for 3 cycles once the first result is valid -> in_ready=0 for exactly those 3 cycles; output holds stable; all 8 results emerge in order, none lost or duplicated. Check every result against a reference model.
- Reset mid-flight and parameter sweep: assert rst with 3 beats in flight -> none emerge. Random 10k beats checked against the reference model at (WIDTH, BLOCK) = (16,4), (16,16), (8,1) and (32,8), verifying latency = WIDTH/BLOCK each time.
